// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The optional overflow output is enabled with the SERIAL_SUB_OVF_EN macro.
package serial_sub_pkg;

    parameter int unsigned DefaultWidth = 8;
    parameter int unsigned DefaultCntW  = $clog2(DefaultWidth);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Keeps the bit counter at least one bit wide, even for degenerate widths.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_unit_if.sv
// Operand/result handshake bundle for serial_sub_unit.
// Carries the ovf line only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_unit_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff_out;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff_out, bout, ovf
    );

    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff_out, bout, ovf
    );
`else
    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff_out, bout
    );

    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff_out, bout
    );
`endif

endinterface

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: dif = a - b - c, bo is the borrow out.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic dif,
    output logic bo
);

    always_comb begin
        dif = a ^ b ^ c;
        bo  = (~a & b) | (~(a ^ b) & c);
    end

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_sub_unit
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic              clk,
    input  logic              rst,
    serial_sub_unit_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] d_sr_q, d_sr_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             cell_dif;
    logic             cell_bo;
    logic             last_bit;
    logic [WIDTH-1:0] d_ext;

    fs_cell u_fs_cell (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .c   (br_q),
        .dif (cell_dif),
        .bo  (cell_bo)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));
    // Fresh difference bit enters at the MSB; on the last step this is the full result.
    assign d_ext    = {cell_dif, d_sr_q};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_sr_d  = bus.a_in;
                    b_sr_d  = bus.b_in;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = d_ext[WIDTH-1:1];
                br_d   = cell_bo;
                cnt_d  = cnt_q + 1'b1;
                if (last_bit) begin
                    diff_d  = d_ext;
                    bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                    // Overflow when borrow into and out of the sign bit differ.
                    ovf_d   = br_q ^ cell_bo;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StShift);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff_out = diff_q;
    assign bus.bout     = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed-vector bench for serial_sub_unit (WIDTH=8); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    serial_sub_unit_if #(.WIDTH(8)) bus ();

    serial_sub_unit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge; returns at the first negedge after acceptance.
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic bi);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.bin   = bi;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        bus.bin   = ~bi;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input logic [7:0] exp_diff, input logic exp_bout);
        int busy_cnt;
        bit got;
        busy_cnt = 0;
        got      = 1'b0;
        accept(a, b, bi);
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".done"}, 32'(got), 32'd1);
        check({tag, ".busy_cycles"}, busy_cnt, 8);
        check({tag, ".diff"}, bus.diff_out, exp_diff);
        check({tag, ".bout"}, bus.bout, exp_bout);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int first_done;
        int second_done;
        int hold_err;

        bus.start = 1'b0;
        bus.a_in  = 8'h00;
        bus.b_in  = 8'h00;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", bus.busy, 1'b0);
        check("rst.done", bus.done, 1'b0);
        check("rst.diff", bus.diff_out, 8'h00);
        check("rst.bout", bus.bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst.ovf", bus.ovf, 1'b0);
`endif
        rst = 1'b0;

        run_op("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run_op("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        run_op("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);

        run_op("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("t3a.ovf", bus.ovf, 1'b1);
`endif
        run_op("t3b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("t3b.ovf", bus.ovf, 1'b0);
`endif

        // Start pulses with different operands at busy cycles 3 and 8 and during done.
        accept(8'h5A, 8'h21, 1'b0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (i == 5) check("t4.diff_hold", bus.diff_out, 8'h0F);
            bus.start = (i == 3 || i == 8 || i == 9);
            bus.a_in  = 8'hFF;
            bus.b_in  = 8'h00;
            bus.bin   = 1'b0;
        end
        bus.start = 1'b0;
        check("t4.busy_cycles", busy_cnt, 8);
        check("t4.done_count", done_cnt, 1);
        check("t4.diff", bus.diff_out, 8'h39);
        check("t4.bout", bus.bout, 1'b0);

        // Reset in the middle of a run.
        accept(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5.busy", bus.busy, 1'b0);
        check("t5.done", bus.done, 1'b0);
        check("t5.diff", bus.diff_out, 8'h00);
        check("t5.bout", bus.bout, 1'b0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("t5.no_done", done_cnt, 0);
        run_op("t5.fresh", 8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0);

        // Start held high: runs accepted every 10 edges.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.a_in    = 8'h20;
        bus.b_in    = 8'h05;
        bus.bin     = 1'b0;
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        hold_err    = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
            if (first_done > 0 && bus.diff_out !== 8'h1B) hold_err++;
        end
        bus.start = 1'b0;
        check("t6.first_done", first_done, 9);
        check("t6.spacing", second_done - first_done, 10);
        check("t6.done_count", done_cnt, 3);
        check("t6.diff_hold", hold_err, 0);
        check("t6.bout", bus.bout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
